mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-ported 16-bit memory between instruction fetch (read-only) and data access (read/write).
//  Sequences each access through issue / wait / respond states.
//  Returns per-requester done pulses, read data and stall flags to the pipeline.
//  Sits between fetch/memory stages and the unified memory instance.
// PARAMETERS
//  MEM_LAT  2   cycles from mem_en to valid mem_rdata; legal 1..15 (4-bit counter)
//  AW       16  address width
//  DW       16  data width
// PORTS
//  clk        in   1   clock; all state changes on rising edge
//  rst        in   1   synchronous reset, active-low
//  if_req     in   1   fetch request; hold with stable if_addr until if_done
//  if_addr    in   AW  fetch address
//  if_done    out  1   one-cycle pulse: fetch access complete
//  if_rdata   out  DW  fetch data; valid while if_done=1, held until next fetch done
//  if_stall   out  1   if_req & ~if_done
//  d_req      in   1   data request; hold with stable d_addr/d_wr/d_wdata until d_done
//  d_wr       in   1   1=write, 0=read
//  d_addr     in   AW  data address
//  d_wdata    in   DW  write data
//  d_done     out  1   one-cycle pulse: data access complete (reads and writes)
//  d_rdata    out  DW  read data; valid while d_done=1, held until next data read done
//  d_stall    out  1   d_req & ~d_done
//  mem_en     out  1   memory enable; high exactly one cycle per access (ISSUE)
//  mem_wr     out  1   memory write strobe; high only in ISSUE of a write
//  mem_addr   out  AW  latched address of the current access
//  mem_wdata  out  DW  latched write data
//  mem_rdata  in   DW  memory read data, valid MEM_LAT cycles after the mem_en cycle
//  err        out  1   sticky protocol error; cleared only by reset
// BEHAVIOUR
//  Reset (rst=0 at edge): state=IDLE; all outputs 0; cnt=0; owner=fetch.
//    Reset mid-access abandons the access with no done pulse.
//  States: IDLE, ISSUE, WAIT, RESP.
//  IDLE/RESP sample requests. If any request is pending:
//    - pick winner; latch owner, addr, wr, wdata
//    - next state ISSUE; else IDLE
//  ISSUE: mem_en=1, mem_wr=latched wr; cnt<=MEM_LAT-1; next WAIT if MEM_LAT>1, else capture.
//  WAIT: decrement cnt. When cnt==0, capture mem_rdata into the owner's rdata reg (reads only), then go to RESP.
//  RESP: owner's done=1 for exactly this cycle.
//    - the other requester may be accepted here (back-to-back)
//    - the finishing owner may also be re-accepted if it raises a new request in the same cycle
//  Latency: request sampled in cycle 0 -> mem_en in cycle 1 -> done in cycle MEM_LAT+2.
//  Priority (no macro): data wins a simultaneous tie (older instruction). Fetch may starve while d_req stays high.
//  Writes never update if_rdata/d_rdata. mem_addr/mem_wdata hold their last values when idle.
//  Protocol errors, each setting err=1:
//    - owner drops req before its done; the access still completes and done still pulses
//    - if_req and a fetch write are impossible; d_wr change while owned sets err
// CONFIGURATION
//  ARB_RR_EN defined: round-robin on ties via last-grant register.
//    - reset value = fetch, so data wins the first tie
//    - afterwards, the requester not granted last wins
//    - non-tie grants are unchanged
//  ARB_RR_EN undefined: fixed data-over-fetch priority; no last-grant register.
// TESTING
//  MEM_LAT=2, if_req=1, if_addr=0x0010, mem_rdata=0xBEEF in cycle 3
//    -> mem_en=1 with mem_addr=0x0010 in cycle 1; if_done=1, if_rdata=0xBEEF in cycle 4; if_stall=1 in cycles 0-3.
//  d_req=1, d_wr=1, d_addr=0x0100, d_wdata=0x1234
//    -> mem_en=mem_wr=1, mem_addr=0x0100, mem_wdata=0x1234 in cycle 1; d_done in cycle 4; d_rdata unchanged.
//  if_req and d_req both rise in cycle 0
//    -> data issued in cycle 1; fetch accepted in data's RESP; fetch mem_en in cycle 5; if_done in cycle 8.
//  ARB_RR_EN, both held high for four accesses
//    -> grants D,F,D,F; without the macro -> D,D,D,D.
//  rst=0 in WAIT of a read
//    -> next cycle all outputs 0, no done; a fresh if_req completes normally with MEM_LAT+2 latency.
//  d_req dropped in WAIT
//    -> err=1 from next cycle, d_done still pulses, err stays 1 until rst=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between instruction fetch
// (read-only) and data access (read/write). Each access runs through the
// states IDLE -> ISSUE -> WAIT -> RESP.
// Define ARB_RR_EN to get round-robin tie breaking through a last-grant
// register. Without it, data always wins a tie.

module mem_arbiter #(
    parameter int unsigned MEM_LAT = 2,
    parameter int unsigned AW      = 16,
    parameter int unsigned DW      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_done,
    output logic [DW-1:0] if_rdata,
    output logic          if_stall,
    input  logic          d_req,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          d_stall,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          err
);

    localparam int unsigned CW = 4;

    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e          state_q, state_d;

    logic            accept;
    logic            grant_data;

    logic [CW-1:0]   cnt_q, cnt_d;
    logic            owner_q, owner_d;
    logic            wr_q, wr_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   if_rdata_q, if_rdata_d;
    logic [DW-1:0]   d_rdata_q, d_rdata_d;
    logic            err_q, err_d;
    logic            mem_en_q, mem_en_d;
    logic            mem_wr_q, mem_wr_d;
    logic            if_done_q, if_done_d;
    logic            d_done_q, d_done_d;

`ifdef ARB_RR_EN
    logic            last_grant_q, last_grant_d;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and winner selection
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        grant_data = 1'b0;

`ifdef ARB_RR_EN
        // On a tie the requester not granted last time wins
        if (if_req && d_req) begin
            grant_data = (last_grant_q == OWN_FETCH);
        end else begin
            grant_data = d_req;
        end
`else
        grant_data = d_req;
`endif

        case (state_q)
            S_IDLE, S_RESP: begin
                if (if_req || d_req) begin
                    accept  = 1'b1;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath, registered-output and protocol-check next values
    always_comb begin
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        err_d      = err_q;
`ifdef ARB_RR_EN
        last_grant_d = last_grant_q;
`endif

        // Latch the winner's request at acceptance
        if (accept) begin
            owner_d = grant_data ? OWN_DATA : OWN_FETCH;
            addr_d  = grant_data ? d_addr : if_addr;
            wr_d    = grant_data & d_wr;
            if (grant_data) begin
                wdata_d = d_wdata;
            end
`ifdef ARB_RR_EN
            last_grant_d = grant_data ? OWN_DATA : OWN_FETCH;
`endif
        end

        case (state_q)
            S_ISSUE: begin
                cnt_d = CW'(MEM_LAT - 1);
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    // Read data is valid this cycle; writes leave both regs alone
                    if (!wr_q) begin
                        if (owner_q == OWN_DATA) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            if_rdata_d = mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
            end
        endcase

        // Owner must hold its request (and, for data, its direction) until done
        if ((state_q == S_ISSUE) || (state_q == S_WAIT)) begin
            if (owner_q == OWN_DATA) begin
                if (!d_req || (d_wr != wr_q)) begin
                    err_d = 1'b1;
                end
            end else begin
                if (!if_req) begin
                    err_d = 1'b1;
                end
            end
        end

        mem_en_d  = (state_d == S_ISSUE);
        mem_wr_d  = (state_d == S_ISSUE) && wr_d;
        if_done_d = (state_q == S_WAIT) && (cnt_q == '0) && (owner_q == OWN_FETCH);
        d_done_d  = (state_q == S_WAIT) && (cnt_q == '0) && (owner_q == OWN_DATA);
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q      <= '0;
            owner_q    <= OWN_FETCH;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            err_q      <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
`ifdef ARB_RR_EN
            last_grant_q <= OWN_FETCH;
`endif
        end else begin
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            err_q      <= err_d;
            mem_en_q   <= mem_en_d;
            mem_wr_q   <= mem_wr_d;
            if_done_q  <= if_done_d;
            d_done_q   <= d_done_d;
`ifdef ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign if_done   = if_done_q;
    assign if_rdata  = if_rdata_q;
    assign d_done    = d_done_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign err       = err_q;

    // Stalls follow the live request so the pipeline freezes in the request cycle
    assign if_stall  = if_req & ~if_done_q;
    assign d_stall   = d_req & ~d_done_q;

endmodule
